sector_block_buffer: RTL and testbench

SECTOR_BLOCK_BUFFER -- requirements
Module: sector_block_buffer

---
 rtl/block_buffer_pkg.sv | 31 +++
 rtl/sector_we_decoder.sv | 21 ++
 rtl/sector_block_buffer.sv | 228 ++++++++++++++++++++++
 tb/tb_sector_block_buffer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/block_buffer_pkg.sv
// Shared widths, address-split helpers and FSM encoding for the sector block buffer.
package block_buffer_pkg;

    localparam int unsigned DEFAULT_ADDR_W      = 64;
    localparam int unsigned DEFAULT_SECTOR_W    = 64;
    localparam int unsigned DEFAULT_NUM_SECTORS = 8;

    typedef enum logic [2:0] {
        StIdle,
        StResp,
        StWb,
        StFillReq,
        StFillWait
    } state_e;

    // Byte-offset bits inside one sector.
    function automatic int unsigned off_lo(input int unsigned sector_w);
        return $clog2(sector_w / 8);
    endfunction

    function automatic int unsigned idx_w(input int unsigned num_sectors);
        return $clog2(num_sectors);
    endfunction

    // Lowest address bit belonging to the tag.
    function automatic int unsigned tag_lo(input int unsigned sector_w,
                                           input int unsigned num_sectors);
        return off_lo(sector_w) + idx_w(num_sectors);
    endfunction

endpackage

// File: rtl/sector_we_decoder.sv
// Sector write-enable decoder: all-ones for a block fill, one-hot for a sector write.
module sector_we_decoder #(
    parameter int unsigned NUM_SECTORS = 8,
    parameter int unsigned IDX_W       = $clog2(NUM_SECTORS)
) (
    input  logic                   we_all,
    input  logic                   we_specific,
    input  logic [IDX_W-1:0]       index,
    output logic [NUM_SECTORS-1:0] we
);

    always_comb begin
        we = '0;
        if (we_all) begin
            we = '1;
        end else if (we_specific) begin
            we[index] = 1'b1;
        end
    end

endmodule

// File: rtl/sector_block_buffer.sv
// Single-block write-back buffer serving sector-sized client accesses from a block memory.
module sector_block_buffer
    import block_buffer_pkg::*;
#(
    parameter int unsigned ADDR_W      = DEFAULT_ADDR_W,
    parameter int unsigned SECTOR_W    = DEFAULT_SECTOR_W,
    parameter int unsigned NUM_SECTORS = DEFAULT_NUM_SECTORS,
    parameter int unsigned BLOCK_W     = SECTOR_W * NUM_SECTORS
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_is_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [SECTOR_W-1:0] req_data,

    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [SECTOR_W-1:0] resp_data,

    input  logic                flush,
    output logic                flush_done,

    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_req_is_write,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic [BLOCK_W-1:0]  mem_req_data,

    input  logic                mem_resp_valid,
    input  logic [BLOCK_W-1:0]  mem_resp_data
);

    localparam int unsigned OFF_LO = off_lo(SECTOR_W);
    localparam int unsigned IDX_W  = idx_w(NUM_SECTORS);
    localparam int unsigned TAG_LO = tag_lo(SECTOR_W, NUM_SECTORS);
    localparam int unsigned TAG_W  = ADDR_W - TAG_LO;

    state_e                state_q, state_d;
    logic [BLOCK_W-1:0]    data_q, data_d;
    logic [TAG_W-1:0]      tag_q, tag_d;
    logic                  valid_q, valid_d;
    logic                  dirty_q, dirty_d;
    logic                  lat_is_write_q, lat_is_write_d;
    logic [IDX_W-1:0]      lat_idx_q, lat_idx_d;
    logic [TAG_W-1:0]      lat_tag_q, lat_tag_d;
    logic [SECTOR_W-1:0]   lat_data_q, lat_data_d;
    logic [SECTOR_W-1:0]   resp_data_q, resp_data_d;
    logic                  flush_wb_q, flush_wb_d;
    logic                  flush_done_q, flush_done_d;
    logic                  init_done_q;

    logic [IDX_W-1:0]      req_idx;
    logic [TAG_W-1:0]      req_tag;
    logic                  hit;
    logic                  we_all, we_spec;
    logic [IDX_W-1:0]      we_idx;
    logic [SECTOR_W-1:0]   wdata;
    logic [NUM_SECTORS-1:0] sector_we;
    logic                  unused_addr_lo;

    assign req_idx        = req_addr[OFF_LO +: IDX_W];
    assign req_tag        = req_addr[ADDR_W-1:TAG_LO];
    assign hit            = valid_q && (req_tag == tag_q);
    assign unused_addr_lo = ^req_addr[TAG_LO-1:0];

    // Outputs stay quiet until the first clock after reset release.
    assign req_ready        = init_done_q && (state_q == StIdle) && !flush;
    assign resp_valid       = (state_q == StResp);
    assign resp_data        = resp_data_q;
    assign flush_done       = flush_done_q;
    assign mem_req_valid    = (state_q == StWb) || (state_q == StFillReq);
    assign mem_req_is_write = (state_q == StWb);
    assign mem_req_data     = data_q;

    always_comb begin
        mem_req_addr = '0;
        if (state_q == StWb) begin
            mem_req_addr = {tag_q, {TAG_LO{1'b0}}};
        end else if (state_q == StFillReq) begin
            mem_req_addr = {lat_tag_q, {TAG_LO{1'b0}}};
        end
    end

    always_comb begin
        state_d        = state_q;
        tag_d          = tag_q;
        valid_d        = valid_q;
        dirty_d        = dirty_q;
        lat_is_write_d = lat_is_write_q;
        lat_idx_d      = lat_idx_q;
        lat_tag_d      = lat_tag_q;
        lat_data_d     = lat_data_q;
        resp_data_d    = resp_data_q;
        flush_wb_d     = flush_wb_q;
        flush_done_d   = 1'b0;
        we_all         = 1'b0;
        we_spec        = 1'b0;
        we_idx         = lat_idx_q;
        wdata          = lat_data_q;

        unique case (state_q)
            StIdle: begin
                if (init_done_q && flush) begin
                    if (dirty_q) begin
                        flush_wb_d = 1'b1;
                        state_d    = StWb;
                    end else begin
                        flush_done_d = 1'b1;
                    end
                end else if (req_valid && req_ready) begin
                    lat_is_write_d = req_is_write;
                    lat_idx_d      = req_idx;
                    lat_tag_d      = req_tag;
                    lat_data_d     = req_data;
                    if (hit) begin
                        state_d = StResp;
                        if (req_is_write) begin
                            we_spec     = 1'b1;
                            we_idx      = req_idx;
                            wdata       = req_data;
                            dirty_d     = 1'b1;
                            resp_data_d = req_data;
                        end else begin
                            resp_data_d = data_q[req_idx*SECTOR_W +: SECTOR_W];
                        end
                    end else begin
                        flush_wb_d = 1'b0;
                        state_d    = dirty_q ? StWb : StFillReq;
                    end
                end
            end
            StWb: begin
                if (mem_req_ready) begin
                    dirty_d = 1'b0;
                    if (flush_wb_q) begin
                        flush_done_d = 1'b1;
                        state_d      = StIdle;
                    end else begin
                        state_d = StFillReq;
                    end
                end
            end
            StFillReq: begin
                if (mem_req_ready) begin
                    state_d = StFillWait;
                end
            end
            StFillWait: begin
                if (mem_resp_valid) begin
                    we_all  = 1'b1;
                    we_spec = lat_is_write_q;
                    tag_d   = lat_tag_q;
                    valid_d = 1'b1;
                    dirty_d = lat_is_write_q;
                    resp_data_d = lat_is_write_q ? lat_data_q
                                                 : mem_resp_data[lat_idx_q*SECTOR_W +: SECTOR_W];
                    state_d = StResp;
                end
            end
            StResp: begin
                if (resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    sector_we_decoder #(
        .NUM_SECTORS (NUM_SECTORS),
        .IDX_W       (IDX_W)
    ) u_we_dec (
        .we_all      (we_all),
        .we_specific (we_spec),
        .index       (we_idx),
        .we          (sector_we)
    );

    // A latched write during fill overrides the fill data of its own sector.
    always_comb begin
        data_d = data_q;
        for (int unsigned s = 0; s < NUM_SECTORS; s++) begin
            if (sector_we[s]) begin
                if (we_all && !(we_spec && (we_idx == IDX_W'(s)))) begin
                    data_d[s*SECTOR_W +: SECTOR_W] = mem_resp_data[s*SECTOR_W +: SECTOR_W];
                end else begin
                    data_d[s*SECTOR_W +: SECTOR_W] = wdata;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            data_q         <= '0;
            tag_q          <= '0;
            valid_q        <= 1'b0;
            dirty_q        <= 1'b0;
            lat_is_write_q <= 1'b0;
            lat_idx_q      <= '0;
            lat_tag_q      <= '0;
            lat_data_q     <= '0;
            resp_data_q    <= '0;
            flush_wb_q     <= 1'b0;
            flush_done_q   <= 1'b0;
            init_done_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            data_q         <= data_d;
            tag_q          <= tag_d;
            valid_q        <= valid_d;
            dirty_q        <= dirty_d;
            lat_is_write_q <= lat_is_write_d;
            lat_idx_q      <= lat_idx_d;
            lat_tag_q      <= lat_tag_d;
            lat_data_q     <= lat_data_d;
            resp_data_q    <= resp_data_d;
            flush_wb_q     <= flush_wb_d;
            flush_done_q   <= flush_done_d;
            init_done_q    <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sector_block_buffer.sv
// Directed bench for sector_block_buffer with hand-computed expected values.
module tb_sector_block_buffer;

    localparam int unsigned ADDR_W  = 64;
    localparam int unsigned SECTOR_W = 64;
    localparam int unsigned NSEC    = 8;
    localparam int unsigned BLOCK_W = SECTOR_W * NSEC;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                req_valid = 1'b0;
    logic                req_ready;
    logic                req_is_write = 1'b0;
    logic [ADDR_W-1:0]   req_addr = '0;
    logic [SECTOR_W-1:0] req_data = '0;
    logic                resp_valid;
    logic                resp_ready = 1'b0;
    logic [SECTOR_W-1:0] resp_data;
    logic                flush = 1'b0;
    logic                flush_done;
    logic                mem_req_valid;
    logic                mem_req_ready = 1'b0;
    logic                mem_req_is_write;
    logic [ADDR_W-1:0]   mem_req_addr;
    logic [BLOCK_W-1:0]  mem_req_data;
    logic                mem_resp_valid = 1'b0;
    logic [BLOCK_W-1:0]  mem_resp_data = '0;

    int n_checks = 0;
    int n_pass   = 0;
    int mem_hs   = 0;
    int resp_hs  = 0;
    int fd_cnt   = 0;
    logic [BLOCK_W-1:0] wb_seen;
    logic [BLOCK_W-1:0] fill1, fill2, exp_blk;
    int base_mem, base_resp, base_fd;

    sector_block_buffer #(
        .ADDR_W      (ADDR_W),
        .SECTOR_W    (SECTOR_W),
        .NUM_SECTORS (NSEC)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_is_write     (req_is_write),
        .req_addr         (req_addr),
        .req_data         (req_data),
        .resp_valid       (resp_valid),
        .resp_ready       (resp_ready),
        .resp_data        (resp_data),
        .flush            (flush),
        .flush_done       (flush_done),
        .mem_req_valid    (mem_req_valid),
        .mem_req_ready    (mem_req_ready),
        .mem_req_is_write (mem_req_is_write),
        .mem_req_addr     (mem_req_addr),
        .mem_req_data     (mem_req_data),
        .mem_resp_valid   (mem_resp_valid),
        .mem_resp_data    (mem_resp_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_req_valid && mem_req_ready) mem_hs++;
        if (resp_valid && resp_ready) resp_hs++;
        if (flush_done) fd_cnt++;
    end

    task automatic check(input string tag, input logic [BLOCK_W-1:0] got,
                         input logic [BLOCK_W-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_req(input logic wr, input logic [ADDR_W-1:0] addr,
                            input logic [SECTOR_W-1:0] data);
        int n = 0;
        req_valid = 1'b1;
        req_is_write = wr;
        req_addr = addr;
        req_data = data;
        while (!req_ready && n < 20) begin
            step();
            n++;
        end
        check("req_ready_wait", BLOCK_W'(req_ready), 1);
        step();
        req_valid = 1'b0;
    endtask

    task automatic mem_accept(input string tag, input logic exp_wr,
                              input logic [ADDR_W-1:0] exp_addr, input int stall);
        int n = 0;
        logic stable = 1'b1;
        logic [ADDR_W-1:0] a;
        logic [BLOCK_W-1:0] d;
        while (!mem_req_valid && n < 20) begin
            step();
            n++;
        end
        check({tag, "_valid"}, BLOCK_W'(mem_req_valid), 1);
        check({tag, "_is_write"}, BLOCK_W'(mem_req_is_write), BLOCK_W'(exp_wr));
        check({tag, "_addr"}, BLOCK_W'(mem_req_addr), BLOCK_W'(exp_addr));
        a = mem_req_addr;
        d = mem_req_data;
        for (int i = 0; i < stall; i++) begin
            step();
            if (!mem_req_valid || mem_req_addr !== a || mem_req_data !== d ||
                mem_req_is_write !== exp_wr) stable = 1'b0;
        end
        if (stall > 0) check({tag, "_stable"}, BLOCK_W'(stable), 1);
        wb_seen = mem_req_data;
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
    endtask

    task automatic mem_fill(input logic [BLOCK_W-1:0] blk);
        mem_resp_valid = 1'b1;
        mem_resp_data = blk;
        step();
        mem_resp_valid = 1'b0;
        mem_resp_data = '0;
    endtask

    task automatic client_resp(input string tag, input logic [SECTOR_W-1:0] exp, input int stall);
        int n = 0;
        logic stable = 1'b1;
        while (!resp_valid && n < 20) begin
            step();
            n++;
        end
        check({tag, "_resp_valid"}, BLOCK_W'(resp_valid), 1);
        check({tag, "_resp_data"}, BLOCK_W'(resp_data), BLOCK_W'(exp));
        for (int i = 0; i < stall; i++) begin
            step();
            if (!resp_valid || resp_data !== exp) stable = 1'b0;
        end
        if (stall > 0) check({tag, "_resp_stable"}, BLOCK_W'(stable), 1);
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        check({tag, "_resp_drop"}, BLOCK_W'(resp_valid), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, BLOCK_W'(req_ready), 0);
        check({tag, "_resp_valid"}, BLOCK_W'(resp_valid), 0);
        check({tag, "_flush_done"}, BLOCK_W'(flush_done), 0);
        check({tag, "_mem_valid"}, BLOCK_W'(mem_req_valid), 0);
        check({tag, "_mem_is_write"}, BLOCK_W'(mem_req_is_write), 0);
        check({tag, "_mem_addr"}, BLOCK_W'(mem_req_addr), 0);
        check({tag, "_resp_data"}, BLOCK_W'(resp_data), 0);
    endtask

    initial begin
        for (int k = 0; k < int'(NSEC); k++) begin
            fill1[k*SECTOR_W +: SECTOR_W] = SECTOR_W'(k);
            fill2[k*SECTOR_W +: SECTOR_W] = SECTOR_W'(32'h100 + k);
        end

        #3;
        check_reset_outputs("reset");
        step();
        rst_n = 1'b1;
        step();
        step();

        // Cold read: clean miss goes straight to fill.
        base_mem = mem_hs;
        send_req(1'b0, 64'h1000, '0);
        mem_accept("cold_fill", 1'b0, 64'h1000, 0);
        mem_fill(fill1);
        client_resp("cold", 64'h0, 0);
        check("cold_no_wb", BLOCK_W'(mem_hs - base_mem), 1);

        // Write hit to sector 3, then read hits with one-cycle latency.
        base_mem = mem_hs;
        send_req(1'b1, 64'h1018, 64'hDEAD);
        check("wr_hit_latency", BLOCK_W'(resp_valid), 1);
        client_resp("wr_hit", 64'hDEAD, 0);
        send_req(1'b0, 64'h1018, '0);
        check("rd_hit_latency", BLOCK_W'(resp_valid), 1);
        client_resp("rd_hit3", 64'hDEAD, 0);
        send_req(1'b0, 64'h1010, '0);
        client_resp("rd_hit2", 64'h2, 0);
        send_req(1'b0, 64'h1038, '0);
        client_resp("rd_hit7", 64'h7, 0);
        check("hit_no_mem", BLOCK_W'(mem_hs - base_mem), 0);

        // Dirty miss: write-back under backpressure, then fill; held response.
        base_mem = mem_hs;
        base_resp = resp_hs;
        exp_blk = fill1;
        exp_blk[3*SECTOR_W +: SECTOR_W] = 64'hDEAD;
        send_req(1'b0, 64'h2008, '0);
        mem_accept("wb", 1'b1, 64'h1000, 3);
        check("wb_data", wb_seen, exp_blk);
        mem_accept("fill2", 1'b0, 64'h2000, 0);
        mem_fill(fill2);
        client_resp("miss_rd", 64'h101, 5);
        check("miss_mem_hs", BLOCK_W'(mem_hs - base_mem), 2);
        check("miss_resp_hs", BLOCK_W'(resp_hs - base_resp), 1);

        // Flush beats a simultaneous request on a dirty block.
        send_req(1'b1, 64'h2020, 64'hBEEF);
        client_resp("wr4", 64'hBEEF, 0);
        base_fd = fd_cnt;
        flush = 1'b1;
        req_valid = 1'b1;
        req_is_write = 1'b0;
        req_addr = 64'h2020;
        #0;
        check("flush_blocks_req", BLOCK_W'(req_ready), 0);
        step();
        flush = 1'b0;
        exp_blk = fill2;
        exp_blk[4*SECTOR_W +: SECTOR_W] = 64'hBEEF;
        mem_accept("flush_wb", 1'b1, 64'h2000, 0);
        check("flush_wb_data", wb_seen, exp_blk);
        check("flush_done_pulse", BLOCK_W'(flush_done), 1);
        check("flush_no_early_resp", BLOCK_W'(resp_valid), 0);
        step();
        req_valid = 1'b0;
        check("flush_done_drop", BLOCK_W'(flush_done), 0);
        check("req_after_flush", BLOCK_W'(resp_valid), 1);
        client_resp("post_flush", 64'hBEEF, 0);
        check("flush_pulses", BLOCK_W'(fd_cnt - base_fd), 1);

        // Flush on clean block: pulse only.
        base_mem = mem_hs;
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("clean_flush_done", BLOCK_W'(flush_done), 1);
        check("clean_flush_no_mem", BLOCK_W'(mem_req_valid), 0);
        step();
        check("clean_flush_drop", BLOCK_W'(flush_done), 0);
        check("clean_flush_mem_hs", BLOCK_W'(mem_hs - base_mem), 0);

        // Reset during FILL_WAIT abandons the miss.
        send_req(1'b0, 64'h3000, '0);
        mem_accept("rst_fill", 1'b0, 64'h3000, 0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        step();
        rst_n = 1'b1;
        base_mem = mem_hs;
        mem_fill(fill1);
        step();
        step();
        check("late_fill_no_resp", BLOCK_W'(resp_valid), 0);
        check("late_fill_no_mem", BLOCK_W'(mem_req_valid), 0);
        check("late_fill_mem_hs", BLOCK_W'(mem_hs - base_mem), 0);
        send_req(1'b0, 64'h2020, '0);
        mem_accept("post_rst_miss", 1'b0, 64'h2000, 0);
        mem_fill(fill2);
        client_resp("post_rst", 64'h104, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
